// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Write-side controller of an asynchronous FIFO. Keeps the
//               binary/Gray write pointer, generates the RAM write enable and
//               address, a registered pessimistic full flag and a sticky
//               overflow flag. With FIFO_WLEVEL_EN defined it also produces a
//               registered occupancy estimate and an almost-full flag;
//               without it those outputs are tied to zero.
// Ports       : wclk         - write-domain clock
//               wrst_n       - synchronous active-low reset
//               winc         - write request
//               wq2_rptr     - Gray read pointer synchronised into wclk
//               wovf_clr     - clears the sticky overflow flag
//               wclken       - RAM write enable
//               waddr        - RAM write address
//               wptr         - registered Gray write pointer
//               wfull        - FIFO full (registered)
//               walmost_full - almost full (registered)
//               wlevel       - occupancy estimate 0..2^ADDR_SIZE
//               woverflow    - sticky write-while-full flag
// Macro       : FIFO_WLEVEL_EN enables wlevel / walmost_full.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl #(
    parameter int ADDR_SIZE   = 8,
    parameter int AFULL_LEVEL = 4
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    input  logic                 wovf_clr,
    output logic                 wclken,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 woverflow
);

    localparam int c_PW = ADDR_SIZE + 1;

    logic [ADDR_SIZE:0] r_wbin;
    logic [ADDR_SIZE:0] r_wptr;
    logic               r_wfull;
    logic               r_wovf;

    logic [ADDR_SIZE:0] w_wbinnext;
    logic [ADDR_SIZE:0] w_wgraynext;
    logic [ADDR_SIZE:0] w_rptr_full;

    // Reset gates the enable so a burst interrupted by reset never writes RAM.
    assign wclken      = winc & ~r_wfull & wrst_n;
    assign waddr       = r_wbin[ADDR_SIZE-1:0];
    assign w_wbinnext  = r_wbin + c_PW'(wclken);
    assign w_wgraynext = w_wbinnext ^ (w_wbinnext >> 1);

    // Full when the write pointer has lapped the read pointer exactly once:
    // in Gray code that is equality with the top two read bits inverted.
    assign w_rptr_full = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_wfull <= 1'b0;
            r_wovf  <= 1'b0;
        end else begin
            r_wbin  <= w_wbinnext;
            r_wptr  <= w_wgraynext;
            r_wfull <= (w_wgraynext == w_rptr_full);
            // Set has priority so a rejected write is never lost to a clear.
            if (winc && r_wfull) begin
                r_wovf <= 1'b1;
            end else if (wovf_clr) begin
                r_wovf <= 1'b0;
            end
        end
    end

    assign wptr      = r_wptr;
    assign wfull     = r_wfull;
    assign woverflow = r_wovf;

`ifdef FIFO_WLEVEL_EN
    localparam logic [ADDR_SIZE:0] c_AFULL_THRESH = c_PW'((2 ** ADDR_SIZE) - AFULL_LEVEL);

    logic [ADDR_SIZE:0] w_rbin;
    logic [ADDR_SIZE:0] w_occ;
    logic [ADDR_SIZE:0] r_wlevel;
    logic               r_wafull;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            w_rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // Modular difference stays correct across the pointer wrap.
    assign w_occ = w_wbinnext - w_rbin;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wlevel <= '0;
            r_wafull <= 1'b0;
        end else begin
            r_wlevel <= w_occ;
            r_wafull <= (w_occ >= c_AFULL_THRESH);
        end
    end

    assign wlevel       = r_wlevel;
    assign walmost_full = r_wafull;
`else
    assign wlevel       = '0;
    assign walmost_full = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, meaning RAM address width; FIFO depth = 2^ADDR_SIZE.
REQ-002 SHALL have parameter AFULL_LEVEL, default 4, meaning free-slot count at or below which walmost_full asserts.
REQ-003 SHALL have port wclk  input  1  write-domain clock; one clock only, all state on posedge wclk.
REQ-004 SHALL have port wrst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port winc  input  1  write request for this cycle.
REQ-006 SHALL have port wq2_rptr  input  ADDR_SIZE+1  Gray read pointer, already synchronized into wclk.
REQ-007 SHALL have port wovf_clr  input  1  clears sticky overflow.
REQ-008 SHALL have port wclken  output  1  RAM write enable toward the dual-port RAM.
REQ-009 SHALL have port waddr  output  ADDR_SIZE  RAM write address.
REQ-010 SHALL have port wptr  output  ADDR_SIZE+1  registered Gray write pointer for the read-side synchronizer.
REQ-011 SHALL have port wfull  output  1  FIFO full, registered.
REQ-012 SHALL have port walmost_full  output  1  almost-full flag, registered.
REQ-013 SHALL have port wlevel  output  ADDR_SIZE+1  occupancy estimate 0..2^ADDR_SIZE, registered.
REQ-014 SHALL have port woverflow  output  1  sticky write-while-full flag.

Function
REQ-015 SHALL hold binary write pointer wbin, ADDR_SIZE+1 bits, MSB as wrap bit.
REQ-016 SHALL drive wclken = winc & ~wfull combinationally; a write is accepted only in such a cycle.
REQ-017 SHALL drive waddr = wbin[ADDR_SIZE-1:0] combinationally; RAM captures data at the same edge wbin advances.
REQ-018 SHALL compute wbinnext = wbin + wclken, modulo 2^(ADDR_SIZE+1), and register wbin <= wbinnext.
REQ-019 SHALL register wptr <= wbinnext ^ (wbinnext >> 1); successive wptr values SHALL differ in exactly one bit.
REQ-020 SHALL register wfull <= (Gray(wbinnext) == wq2_rptr with its two MSBs inverted), so the flag reflects the accepted write one edge later.
REQ-021 SHALL deassert wfull only after an advanced wq2_rptr is sampled; pessimistic full is required, optimistic full is forbidden.
REQ-022 SHALL convert wq2_rptr to binary rbin combinationally (XOR-prefix from MSB).
REQ-023 SHALL register wlevel <= (wbinnext - rbin) modulo 2^(ADDR_SIZE+1); value 2^ADDR_SIZE coincides with full.
REQ-024 SHALL register walmost_full <= (wbinnext - rbin) >= 2^ADDR_SIZE - AFULL_LEVEL.
REQ-025 SHALL set woverflow on the edge after any cycle with winc=1 and wfull=1; the rejected write SHALL not modify wbin, wptr, or RAM.
REQ-026 SHALL clear woverflow on wovf_clr=1; simultaneous set and clear SHALL leave woverflow=1.
REQ-027 SHALL wrap wbin from 2^(ADDR_SIZE+1)-1 to 0 without disturbing wfull, wlevel, or the Gray sequence.

Reset
REQ-028 SHALL, on posedge wclk with wrst_n=0, set wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
REQ-029 SHALL force wclken=0 while wrst_n=0, including reset mid-burst; winc during reset SHALL be ignored.

Configuration
REQ-030 SHALL, with FIFO_WLEVEL_EN defined, implement wlevel and walmost_full per REQ-023/024.
REQ-031 SHALL, without FIFO_WLEVEL_EN, omit the binary conversion and subtractor and tie wlevel=0 and walmost_full=0; all other behaviour SHALL be unchanged and the port list SHALL be identical.

Verification
REQ-032 SHALL cover reset: wrst_n=0 for 2 cycles with winc=1 -> all outputs 0, wclken=0, no RAM write.
REQ-033 SHALL cover fill (ADDR_SIZE=8, wq2_rptr=0): 256 consecutive winc -> wfull=1 after the 256th edge, wlevel=256, wptr=9'h180; 257th winc -> wclken=0, woverflow=1 next cycle.
REQ-034 SHALL cover almost-full (AFULL_LEVEL=4): 251 writes -> walmost_full=0; 252nd write -> walmost_full=1.
REQ-035 SHALL cover drain and wrap: full, then wq2_rptr=Gray(1) -> wfull=0 next edge; 512+ total writes with a tracking read pointer -> waddr wraps 255->0, one-bit wptr changes checked every write.
REQ-036 SHALL cover overflow clear: winc=1 while full together with wovf_clr=1 -> woverflow stays 1; next cycle wovf_clr=1, winc=0 -> woverflow=0.
REQ-037 SHALL cover reset mid-operation: wrst_n=0 after 100 writes -> wbin, wlevel, wptr return to 0 and the next write targets waddr=0.
